// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Refills one data-cache line from main memory after a load miss. The missing
//   address is latched and aligned to the start of its line. One word is then
//   fetched per memory beat, in ascending order. The finished line is written
//   into the cache arrays with a single fill_valid strobe. A one-cycle settle
//   follows so the cache hit path can re-evaluate before a new miss is accepted.
//
// Ports
//   clock       system clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   miss_req    data-cache miss request
//   miss_addr   load address that missed
//   mem_req     memory word read request (held until mem_ack)
//   mem_addr    word-aligned address of the current beat
//   mem_ack     beat completion, mem_rdata valid this cycle
//   mem_rdata   memory read data
//   fill_valid  one-cycle write strobe into the cache line arrays
//   fill_index  line index to write
//   fill_tag    tag to write
//   fill_data   assembled line, word k at bits [32k+31:32k]
//   busy        high whenever the controller is not idle
//
// LINE_WORDS is expected to be a power of two, at least 2.

module cache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 4
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        miss_req,
  input  logic [31:0]                                 miss_addr,
  output logic                                        mem_req,
  output logic [31:0]                                 mem_addr,
  input  logic                                        mem_ack,
  input  logic [31:0]                                 mem_rdata,
  output logic                                        fill_valid,
  output logic [INDEX_BITS-1:0]                       fill_index,
  output logic [31-INDEX_BITS-$clog2(LINE_WORDS)-2:0] fill_tag,
  output logic [32*LINE_WORDS-1:0]                    fill_data,
  output logic                                        busy
);

  localparam int BEAT_BITS = $clog2(LINE_WORDS);
  localparam int OFF_BITS  = BEAT_BITS + 2;          // byte offset inside a line
  localparam int LINE_BITS = 32 - OFF_BITS;          // line address width
  localparam int DATA_BITS = 32 * LINE_WORDS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WRITE  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t                 state_r,      state_nxt_s;
  logic [BEAT_BITS-1:0]   beat_r,       beat_nxt_s;
  logic [LINE_BITS-1:0]   line_addr_r,  line_addr_nxt_s;
  logic [DATA_BITS-1:0]   line_r,       line_nxt_s;
  logic                   mem_req_r,    mem_req_nxt_s;
  logic [31:0]            mem_addr_r,   mem_addr_nxt_s;
  logic                   fill_valid_r, fill_valid_nxt_s;
  logic [INDEX_BITS-1:0]  fill_index_r, fill_index_nxt_s;
  logic [LINE_BITS-INDEX_BITS-1:0] fill_tag_r, fill_tag_nxt_s;
  logic [DATA_BITS-1:0]   fill_data_r,  fill_data_nxt_s;
  logic                   busy_r,       busy_nxt_s;
  logic [BEAT_BITS-1:0]   beat_inc_s;
  logic [DATA_BITS-1:0]   line_merge_s;

  // The byte offset of the miss address is dropped: refills always start at word 0.
  logic miss_offset_unused_s;
  assign miss_offset_unused_s = ^miss_addr[OFF_BITS-1:0];

  // Beat counter increment; the counter is only as wide as the line so the
  // beat address can never carry into the line address.
  assign beat_inc_s = beat_r + BEAT_BITS'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s      = state_r;
    beat_nxt_s       = beat_r;
    line_addr_nxt_s  = line_addr_r;
    line_nxt_s       = line_r;
    mem_req_nxt_s    = 1'b0;
    mem_addr_nxt_s   = mem_addr_r;
    fill_valid_nxt_s = 1'b0;
    fill_index_nxt_s = fill_index_r;
    fill_tag_nxt_s   = fill_tag_r;
    fill_data_nxt_s  = fill_data_r;
    line_merge_s     = line_r;

    case (state_r)
      ST_IDLE: begin
        if (miss_req) begin
          line_addr_nxt_s = miss_addr[31:OFF_BITS];
          beat_nxt_s      = {BEAT_BITS{1'b0}};
          mem_req_nxt_s   = 1'b1;
          mem_addr_nxt_s  = {miss_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
          state_nxt_s     = ST_FETCH;
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end

      ST_FETCH: begin
        mem_req_nxt_s = 1'b1;
        if (mem_ack) begin
          line_merge_s[{beat_r, 5'd0} +: 32] = mem_rdata;
          line_nxt_s = line_merge_s;
          if (beat_r == LAST_BEAT) begin
            // Last beat: the merged line goes straight to the fill registers
            // so fill_valid and fill_data appear together in WRITE.
            mem_req_nxt_s    = 1'b0;
            beat_nxt_s       = {BEAT_BITS{1'b0}};
            fill_valid_nxt_s = 1'b1;
            fill_index_nxt_s = line_addr_r[INDEX_BITS-1:0];
            fill_tag_nxt_s   = line_addr_r[LINE_BITS-1:INDEX_BITS];
            fill_data_nxt_s  = line_merge_s;
            state_nxt_s      = ST_WRITE;
          end else begin
            beat_nxt_s     = beat_inc_s;
            mem_addr_nxt_s = {line_addr_r, beat_inc_s, 2'b00};
          end
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end

      ST_WRITE: begin
        state_nxt_s = ST_SETTLE;
      end

      // miss_req is deliberately not looked at here.
      ST_SETTLE: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      beat_r       <= {BEAT_BITS{1'b0}};
      line_addr_r  <= {LINE_BITS{1'b0}};
      line_r       <= {DATA_BITS{1'b0}};
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      fill_valid_r <= 1'b0;
      fill_index_r <= {INDEX_BITS{1'b0}};
      fill_tag_r   <= {(LINE_BITS-INDEX_BITS){1'b0}};
      fill_data_r  <= {DATA_BITS{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      beat_r       <= beat_nxt_s;
      line_addr_r  <= line_addr_nxt_s;
      line_r       <= line_nxt_s;
      mem_req_r    <= mem_req_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      fill_valid_r <= fill_valid_nxt_s;
      fill_index_r <= fill_index_nxt_s;
      fill_tag_r   <= fill_tag_nxt_s;
      fill_data_r  <= fill_data_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign fill_valid = fill_valid_r;
  assign fill_index = fill_index_r;
  assign fill_tag   = fill_tag_r;
  assign fill_data  = fill_data_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl
//   Self-checking bench for cache_refill_ctrl with the default geometry
//   (4 words per line, 16 lines). A transaction-level reference model
//   (line base, list of received words, cycles left after the fill)
//   predicts every output every cycle. Directed scenarios are followed by
//   randomized traffic with random waits, spurious acks and resets.

module tb_cache_refill_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = 32'h0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;
  logic         fill_valid;
  logic [3:0]   fill_index;
  logic [23:0]  fill_tag;
  logic [127:0] fill_data;
  logic         busy;

  always #5 clock = ~clock;

  cache_refill_ctrl #(.LINE_WORDS(4), .INDEX_BITS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_index (fill_index),
    .fill_tag   (fill_tag),
    .fill_data  (fill_data),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model state
  bit          m_busy  = 1'b0;
  bit          m_fetch = 1'b0;
  int          m_tail  = 0;
  logic [31:0] m_base  = 32'h0;
  logic [31:0] m_words[$];

  logic         exp_mem_req    = 1'b0;
  logic [31:0]  exp_mem_addr   = 32'h0;
  logic         exp_fill_valid = 1'b0;
  logic [3:0]   exp_idx        = 4'h0;
  logic [23:0]  exp_tag        = 24'h0;
  logic [127:0] exp_data       = 128'h0;
  logic         exp_busy       = 1'b0;

  // Observations of the DUT
  int           fill_count = 0;
  int           last_fill_cycle = 0;
  logic [127:0] last_fill_data = 128'h0;
  logic [3:0]   last_fill_index = 4'h0;
  logic [23:0]  last_fill_tag = 24'h0;
  logic [31:0]  ack_addrs[$];

  // Memory responder policy
  int          ack_wait  = 0;     // fixed wait before each ack, -1 = random
  int          rand_wait = 0;
  int          wait_cnt  = 0;
  bit          rand_mode = 1'b0;
  logic [31:0] data_base = 32'h0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cycle, obs, exp);
    end
  endtask

  // Predicts outputs after a rising edge from the inputs sampled at that edge.
  function automatic void model_update();
    exp_fill_valid = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_fetch = 1'b0; m_tail = 0; m_words.delete();
      exp_mem_req = 1'b0; exp_mem_addr = 32'h0; exp_idx = 4'h0;
      exp_tag = 24'h0; exp_data = 128'h0;
    end else if (!m_busy) begin
      if (miss_req) begin
        m_busy = 1'b1; m_fetch = 1'b1;
        m_base = miss_addr & 32'hFFFF_FFF0;
        m_words.delete();
        exp_mem_req  = 1'b1;
        exp_mem_addr = m_base;
      end
    end else if (m_fetch) begin
      if (mem_ack) begin
        m_words.push_back(mem_rdata);
        if (m_words.size() == 4) begin
          m_fetch = 1'b0; m_tail = 2;     // WRITE then SETTLE still busy
          exp_mem_req    = 1'b0;
          exp_fill_valid = 1'b1;
          exp_idx  = m_base[7:4];
          exp_tag  = m_base[31:8];
          exp_data = {m_words[3], m_words[2], m_words[1], m_words[0]};
        end else begin
          exp_mem_addr = m_base + 32'(4 * m_words.size());
        end
      end
    end else begin
      m_tail--;
      if (m_tail == 0) m_busy = 1'b0;
    end
    exp_busy = m_busy;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    cycle++;
    check_eq("mem_req",    mem_req,    exp_mem_req);
    check_eq("mem_addr",   mem_addr,   exp_mem_addr);
    check_eq("fill_valid", fill_valid, exp_fill_valid);
    check_eq("fill_index", fill_index, exp_idx);
    check_eq("fill_tag",   fill_tag,   exp_tag);
    check_eq("fill_data",  fill_data,  exp_data);
    check_eq("busy",       busy,       exp_busy);
    if (fill_valid === 1'b1) begin
      fill_count++;
      last_fill_cycle = cycle;
      last_fill_data  = fill_data;
      last_fill_index = fill_index;
      last_fill_tag   = fill_tag;
    end
  endtask

  // Drives mem_ack/mem_rdata for the coming cycle.
  task automatic drive_mem();
    int need;
    need = (ack_wait < 0) ? rand_wait : ack_wait;
    if (exp_mem_req === 1'b1) begin
      if (wait_cnt >= need) begin
        mem_ack   = 1'b1;
        mem_rdata = rand_mode ? $urandom() : data_base + 32'(m_words.size());
        ack_addrs.push_back(mem_addr);
        wait_cnt  = 0;
        rand_wait = $urandom_range(0, 3);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom();
        wait_cnt++;
      end
    end else begin
      mem_ack   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom();
      wait_cnt  = 0;
    end
  endtask

  task automatic finish_refill();
    int g;
    g = 0;
    while (m_busy && g < 200) begin
      drive_mem();
      tick();
      g++;
    end
    if (g >= 200) check_eq("refill_bound_busy", busy, 1'b0);
    mem_ack = 1'b0;
  endtask

  task automatic start_miss(input logic [31:0] addr);
    miss_addr = addr;
    miss_req  = 1'b1;
    drive_mem();
    tick();
    miss_req  = 1'b0;
  endtask

  initial begin
    int f0, start, idle_cnt, g;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_fill_data", fill_data, 128'h0);
    reset = 1'b0;
    tick();

    // Zero-wait refill, basic timing and data layout.
    // Cycle 1 is the cycle in which miss_req is first presented.
    ack_wait = 0; data_base = 32'hA0; ack_addrs.delete();
    f0 = fill_count; start = cycle;
    start_miss(32'h0000_1234);
    finish_refill();
    check_eq("s1_fills", fill_count - f0, 1);
    check_eq("s1_fill_cycle", last_fill_cycle - start + 1, 6);
    check_eq("s1_addr0", ack_addrs[0], 32'h0000_1230);
    check_eq("s1_addr1", ack_addrs[1], 32'h0000_1234);
    check_eq("s1_addr2", ack_addrs[2], 32'h0000_1238);
    check_eq("s1_addr3", ack_addrs[3], 32'h0000_123C);
    check_eq("s1_index", last_fill_index, 4'h3);
    check_eq("s1_tag", last_fill_tag, 24'h000012);
    check_eq("s1_data", last_fill_data, 128'h000000A3_000000A2_000000A1_000000A0);
    tick();

    // Three wait cycles before every ack
    ack_wait = 3; data_base = 32'h100;
    f0 = fill_count; start = cycle;
    start_miss(32'h8765_4328);
    finish_refill();
    check_eq("s2_fills", fill_count - f0, 1);
    check_eq("s2_fill_cycle", last_fill_cycle - start + 1, 18);
    check_eq("s2_data", last_fill_data, 128'h00000103_00000102_00000101_00000100);
    tick();

    // Miss address changes after being latched
    ack_wait = 1; data_base = 32'h200;
    start_miss(32'h00AB_CD5C);
    miss_addr = 32'hFFFF_FFF0;
    finish_refill();
    check_eq("s3_index", last_fill_index, 4'h5);
    check_eq("s3_tag", last_fill_tag, 24'h00ABCD);
    tick();

    // Reset after the ack of beat 2, with an ack in the reset cycle
    ack_wait = 0; data_base = 32'hC0;
    f0 = fill_count;
    start_miss(32'h0000_4440);
    g = 0;
    while (m_words.size() < 3 && g < 20) begin
      drive_mem(); tick(); g++;
    end
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    check_eq("s4_rst_mem_req", mem_req, 1'b0);
    check_eq("s4_rst_busy", busy, 1'b0);
    tick(); tick();
    check_eq("s4_no_fill", fill_count - f0, 0);
    ack_addrs.delete(); data_base = 32'hD0;
    start_miss(32'h0000_4448);
    finish_refill();
    check_eq("s4_restart_addr0", ack_addrs[0], 32'h0000_4440);
    check_eq("s4_restart_data", last_fill_data, 128'h000000D3_000000D2_000000D1_000000D0);
    tick();

    // miss_req held high: back-to-back refills with a single idle cycle
    ack_wait = 0; data_base = 32'h300;
    f0 = fill_count; idle_cnt = 0;
    miss_addr = 32'h0000_0770; miss_req = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive_mem(); tick();
      if (busy === 1'b0) idle_cnt++;
    end
    miss_req = 1'b0;
    check_eq("s5_fills_held", fill_count - f0, 2);
    check_eq("s5_idle_gap", idle_cnt, 1);
    finish_refill();
    for (int i = 0; i < 4; i++) tick();
    check_eq("s5_fills_after_drop", fill_count - f0, 2);

    // Spurious acks while idle
    f0 = fill_count;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom();
      tick();
    end
    mem_ack = 1'b0;
    check_eq("s6_idle_busy", busy, 1'b0);
    check_eq("s6_no_fill", fill_count - f0, 0);

    // Randomized traffic
    rand_mode = 1'b1; ack_wait = -1;
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 149) == 0);
      miss_req  = ($urandom_range(0, 2) == 0);
      miss_addr = $urandom();
      drive_mem();
      tick();
    end
    reset = 1'b0; miss_req = 1'b0; rand_mode = 1'b0;
    finish_refill();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
